// File: rtl/acc_bcd_display.sv
// Display stage for the 8-bit add/sub accumulator: signed value -> sign + 3 BCD digits
// via a one-bit-per-clock double-dabble engine, plus a sticky overflow LED.
module acc_bcd_display #(
  parameter bit LZB = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  S,
  input  logic        OF,
  input  logic        ClrOF,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0,
  output logic [11:0] BCD,
  output logic        Neg,
  output logic        Valid,
  output logic        OFLed
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg;
  logic [7:0]  mag_reg;
  logic [11:0] scratch_reg;
  logic [2:0]  cnt_reg;
  logic        neg_reg;

  logic [6:0]  hex3_reg, hex2_reg, hex1_reg, hex0_reg;
  logic [11:0] bcd_reg;
  logic        neg_out_reg;
  logic        valid_reg;
  logic        ofled_reg;

  logic [11:0] scratch_adj;
  logic [3:0]  hund, tens, ones;
  logic [6:0]  hex2_next, hex1_next, hex0_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction on every nibble that would overflow past 9 after doubling
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                  ? scratch_reg[gi*4 +: 4] + 4'd3
                                  : scratch_reg[gi*4 +: 4];
  end

  assign hund = scratch_reg[11:8];
  assign tens = scratch_reg[7:4];
  assign ones = scratch_reg[3:0];

  assign hex2_next = (LZB && hund == 4'd0) ? SEG_BLANK : seg7(hund);
  assign hex1_next = (LZB && hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg7(tens);
  assign hex0_next = seg7(ones);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= IDLE;
      mag_reg     <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      neg_reg     <= 1'b0;
      hex3_reg    <= SEG_BLANK;
      hex2_reg    <= SEG_BLANK;
      hex1_reg    <= SEG_BLANK;
      hex0_reg    <= 7'h40;
      bcd_reg     <= '0;
      neg_out_reg <= 1'b0;
      valid_reg   <= 1'b0;
      ofled_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      // Clear first so a same-edge capture of OF overrides it
      if (ClrOF) ofled_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          neg_reg     <= S[7];
          mag_reg     <= S[7] ? (~S + 8'd1) : S;
          scratch_reg <= '0;
          cnt_reg     <= '0;
          if (OF) ofled_reg <= 1'b1;
          state_reg   <= SHIFT;
        end
        SHIFT: begin
          {scratch_reg, mag_reg} <= {scratch_adj[10:0], mag_reg, 1'b0};
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) state_reg <= DONE;
        end
        DONE: begin
          hex3_reg    <= neg_reg ? SEG_MINUS : SEG_BLANK;
          hex2_reg    <= hex2_next;
          hex1_reg    <= hex1_next;
          hex0_reg    <= hex0_next;
          bcd_reg     <= scratch_reg;
          neg_out_reg <= neg_reg;
          valid_reg   <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign HEX3  = hex3_reg;
  assign HEX2  = hex2_reg;
  assign HEX1  = hex1_reg;
  assign HEX0  = hex0_reg;
  assign BCD   = bcd_reg;
  assign Neg   = neg_out_reg;
  assign Valid = valid_reg;
  assign OFLed = ofled_reg;

endmodule

// File: tb/tb_acc_bcd_display.sv
// Bench for acc_bcd_display: vector table, hand-written timing sequences, and
// randomized values checked against an arithmetic decimal/7-seg model.
module tb_acc_bcd_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s = 8'h00;
  logic        of = 1'b0;
  logic        clr_of = 1'b0;

  logic [6:0]  hex3, hex2, hex1, hex0;
  logic [11:0] bcd;
  logic        neg, valid, ofled;
  logic [6:0]  nz_hex3, nz_hex2, nz_hex1, nz_hex0;
  logic [11:0] nz_bcd;
  logic        nz_neg, nz_valid, nz_ofled;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_bcd_display #(.LZB(1'b1)) dut (
    .Clk(clk), .Reset(reset), .S(s), .OF(of), .ClrOF(clr_of),
    .HEX3(hex3), .HEX2(hex2), .HEX1(hex1), .HEX0(hex0),
    .BCD(bcd), .Neg(neg), .Valid(valid), .OFLed(ofled)
  );

  acc_bcd_display #(.LZB(1'b0)) dut_nz (
    .Clk(clk), .Reset(reset), .S(s), .OF(of), .ClrOF(clr_of),
    .HEX3(nz_hex3), .HEX2(nz_hex2), .HEX1(nz_hex1), .HEX0(nz_hex0),
    .BCD(nz_bcd), .Neg(nz_neg), .Valid(nz_valid), .OFLed(nz_ofled)
  );

  typedef struct {
    logic [7:0]  s;
    logic [11:0] bcd;
    logic        neg;
    logic [27:0] hex;
  } vec_t;

  typedef struct packed {
    logic [11:0] bcd;
    logic        neg;
    logic [27:0] hex;
  } res_t;

  vec_t       vecs[10];
  logic [6:0] seg_tab[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid && n < 40);
    if (!valid) check("valid_timeout", 32'(n), 32'd0);
  endtask

  // Decimal digits from plain arithmetic on the signed value
  function automatic res_t model(input logic [7:0] sv, input bit lzb);
    res_t r;
    int v, h, t, o;
    v = sv[7] ? 256 - int'(sv) : int'(sv);
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    r.bcd = {4'(h), 4'(t), 4'(o)};
    r.neg = sv[7];
    r.hex[27:21] = sv[7] ? 7'h3F : 7'h7F;
    r.hex[20:14] = (lzb && h == 0) ? 7'h7F : seg_tab[h];
    r.hex[13:7]  = (lzb && h == 0 && t == 0) ? 7'h7F : seg_tab[t];
    r.hex[6:0]   = seg_tab[o];
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hex"}, {4'h0, hex3, hex2, hex1, hex0}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    check({tag, "_bcd"}, 32'(bcd), 32'd0);
    check({tag, "_neg"}, 32'(neg), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_ofled"}, 32'(ofled), 32'd0);
  endtask

  initial begin
    int n, vcount, first_t, last_t, gap_ok;
    bit ofm;
    res_t r, rn;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    vecs[0] = '{8'h00, 12'h000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[1] = '{8'h7F, 12'h127, 1'b0, {7'h7F, 7'h79, 7'h24, 7'h78}};
    vecs[2] = '{8'h80, 12'h128, 1'b1, {7'h3F, 7'h79, 7'h24, 7'h00}};
    vecs[3] = '{8'hF6, 12'h010, 1'b1, {7'h3F, 7'h7F, 7'h79, 7'h40}};
    vecs[4] = '{8'h05, 12'h005, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vecs[5] = '{8'h63, 12'h099, 1'b0, {7'h7F, 7'h7F, 7'h10, 7'h10}};
    vecs[6] = '{8'h9C, 12'h100, 1'b1, {7'h3F, 7'h79, 7'h40, 7'h40}};
    vecs[7] = '{8'hFF, 12'h001, 1'b1, {7'h3F, 7'h7F, 7'h7F, 7'h79}};
    vecs[8] = '{8'h64, 12'h100, 1'b0, {7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[9] = '{8'h0A, 12'h010, 1'b0, {7'h7F, 7'h7F, 7'h79, 7'h40}};

    // Reset held for 3 edges, released with S = 00
    reset = 1'b1;
    s = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) tick();
    check_reset_outputs("pre_valid");
    wait_valid(n);
    check("first_latency", 32'(n), 32'd5);
    check("first_bcd", 32'(bcd), 32'h000);
    check("first_hex0", 32'(hex0), 32'h40);
    $display("reset release: valid after %0d more edges bcd=%03h", n, bcd);

    // Valid cadence with S = 7F
    s = 8'h7F;
    vcount = 0; first_t = -1; last_t = -1; gap_ok = 1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (valid) begin
        vcount++;
        if (last_t >= 0 && t - last_t != 10) gap_ok = 0;
        if (first_t < 0) first_t = t;
        last_t = t;
      end
    end
    check("valid_count", 32'(vcount), 32'd3);
    check("valid_first", 32'(first_t), 32'd10);
    check("valid_gap", 32'(gap_ok), 32'd1);
    check("cad_bcd", 32'(bcd), 32'h127);
    $display("cadence: %0d valid pulses first at %0d bcd=%03h", vcount, first_t, bcd);

    // Table-driven vectors; each set at a Valid cycle so the next capture sees it
    for (int i = 0; i < 10; i++) begin
      s = vecs[i].s;
      wait_valid(n);
      check("vec_latency", 32'(n), 32'd10);
      check("vec_bcd", 32'(bcd), 32'(vecs[i].bcd));
      check("vec_neg", 32'(neg), 32'(vecs[i].neg));
      check("vec_hex", {4'h0, hex3, hex2, hex1, hex0}, 32'(vecs[i].hex));
      if (vecs[i].s == 8'h05) begin
        check("nz_hex2", 32'(nz_hex2), 32'h40);
        check("nz_hex1", 32'(nz_hex1), 32'h40);
      end
      $display("vec %0d: S=%02h bcd=%03h neg=%0b hex=%02h %02h %02h %02h", i, s, bcd, neg, hex3, hex2, hex1, hex0);
    end

    // S changes while a conversion is in flight
    s = 8'h05;
    repeat (4) tick();
    s = 8'h63;
    wait_valid(n);
    check("inflight_latency", 32'(n), 32'd6);
    check("inflight_bcd", 32'(bcd), 32'h005);
    wait_valid(n);
    check("inflight_next_bcd", 32'(bcd), 32'h099);
    $display("in-flight change: second result bcd=%03h", bcd);

    // Sticky overflow: set on capture only, clear, set-wins
    of = 1'b1;
    tick();
    of = 1'b0;
    check("of_set", 32'(ofled), 32'd1);
    wait_valid(n);
    check("of_hold", 32'(ofled), 32'd1);
    repeat (2) tick();
    clr_of = 1'b1;
    tick();
    clr_of = 1'b0;
    check("of_clear", 32'(ofled), 32'd0);
    of = 1'b1;
    repeat (2) tick();
    of = 1'b0;
    check("of_ignored_in_shift", 32'(ofled), 32'd0);
    wait_valid(n);
    of = 1'b1;
    clr_of = 1'b1;
    tick();
    of = 1'b0;
    clr_of = 1'b0;
    check("of_set_wins", 32'(ofled), 32'd1);
    wait_valid(n);
    $display("overflow sequence: ofled=%0b", ofled);

    // Reset on the 4th SHIFT edge after 127 is shown
    s = 8'h7F;
    wait_valid(n);
    check("pre_abort_bcd", 32'(bcd), 32'h127);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("abort");
    reset = 1'b0;
    wait_valid(n);
    check("post_abort_latency", 32'(n), 32'd10);
    check("post_abort_bcd", 32'(bcd), 32'h127);
    $display("mid-shift reset: next result after %0d edges bcd=%03h", n, bcd);

    // Randomized values against the arithmetic model
    ofm = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s = 8'($urandom);
      of = ($urandom_range(0, 3) == 0);
      ofm = ofm | of;
      r = model(s, 1'b1);
      rn = model(s, 1'b0);
      wait_valid(n);
      check("rnd_latency", 32'(n), 32'd10);
      check("rnd_bcd", 32'(bcd), 32'(r.bcd));
      check("rnd_neg", 32'(neg), 32'(r.neg));
      check("rnd_hex", {4'h0, hex3, hex2, hex1, hex0}, 32'(r.hex));
      check("rnd_nz_hex", {4'h0, nz_hex3, nz_hex2, nz_hex1, nz_hex0}, 32'(rn.hex));
      check("rnd_ofled", 32'(ofled), 32'(ofm));
      $display("rnd %0d: S=%02h OF=%0b bcd=%03h neg=%0b hex=%02h %02h %02h %02h led=%0b",
               i, s, of, bcd, neg, hex3, hex2, hex1, hex0, ofled);
    end
    of = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/acc_bcd_display.md
# acc_bcd_display

Display stage fed by the 8-bit add/sub accumulator. Samples the accumulator's registered signed result `S` and overflow flag `OF` and converts the magnitude to three BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock. It then drives four active-low 7-segment digits: sign, hundreds, tens, ones. Overflow is held in a sticky indicator for the board LED.

## Interface
Parameters:
- `LZB`, default 1: leading-zero blanking enable. 1 blanks leading zero digits; 0 always shows hundreds and tens.

Ports:
- `Clk`  in  1  single clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `S`  in  8  two's-complement accumulator value.
- `OF`  in  1  accumulator overflow flag.
- `ClrOF`  in  1  synchronous clear of sticky overflow indicator.
- `HEX3`  out  7  sign digit, {g,f,e,d,c,b,a}, active-low.
- `HEX2`  out  7  hundreds digit.
- `HEX1`  out  7  tens digit.
- `HEX0`  out  7  ones digit.
- `BCD`  out  12  {hundreds, tens, ones} of the displayed magnitude.
- `Neg`  out  1  displayed value is negative.
- `Valid`  out  1  one-cycle pulse when display outputs update.
- `OFLed`  out  1  sticky overflow indicator.

## Operation
- FSM states:
  - IDLE: 1 cycle. On leaving IDLE, capture `S` and `OF`, set `neg_r = S[7]`, set `mag = S[7] ? -S : S` as 8-bit unsigned. -128 gives 128. Clear BCD scratch, bit counter = 0. IDLE always moves to SHIFT (free-running conversion).
  - SHIFT: 8 cycles. Each edge: add 3 to every scratch BCD nibble ≥ 5, then shift `{scratch, mag}` left 1. After the 8th shift, go to DONE.
  - DONE: 1 cycle. On leaving, load output registers from scratch/`neg_r`, pulse `Valid`, go to IDLE.
- Conversion period is fixed at 10 cycles. `S` and `OF` are ignored outside the IDLE capture edge.
- 7-seg codes, hex, active-low:
  - Digits 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
  - Blank: 7F. Minus: 3F (g only).
- `HEX3` is minus if `Neg`, else blank.
- With `LZB=1`:
  - `HEX2` is blank when hundreds = 0.
  - `HEX1` is blank when hundreds = 0 and tens = 0.
  - `HEX0` is always shown.
- `OFLed`: set on the capture edge if captured `OF` = 1. Cleared on an edge with `ClrOF` = 1 only when not set that edge. Set wins over clear.
- Arithmetic: max magnitude 128, so hundreds ≤ 1. BCD nibbles are always 0-9. No other width growth.

## Timing
- Reset values, applied on any edge with `Reset` = 1 regardless of state:
  - FSM in IDLE.
  - `HEX3` = 7F, `HEX2` = 7F, `HEX1` = 7F, `HEX0` = 40.
  - `BCD` = 0, `Neg` = 0, `Valid` = 0, `OFLed` = 0.
- Reset has priority over `ClrOF` and `OF`.
- After reset deasserts, the first capture happens on the first edge. That IDLE cycle lasts 1 cycle, so a new capture occurs every 10 edges.
- Latency: outputs reflect `S` captured 9 edges earlier. `Valid` is high for the cycle right after the update edge.
- Outputs hold their values across a conversion. Partially converted values never appear on outputs.
- Reset mid-SHIFT or mid-DONE: conversion aborts, no `Valid`, all outputs take reset values.
- A change in `S` during SHIFT/DONE does not affect the conversion in flight. It is picked up at the next capture only if still present.

## Test plan
- Reset held 3 cycles, then released with `S` = 00 → before the first `Valid`: `HEX3..0` = 7F, 7F, 7F, 40, `OFLed` = 0. After `Valid`: `BCD` = 000, `HEX0` = 40.
- `S` = 7F → 9 edges after capture: `BCD` = 127, `HEX3..0` = 7F, 79, 24, 78, `Neg` = 0, `Valid` pulses exactly once per 10 cycles.
- `S` = 80 → `BCD` = 128, `Neg` = 1, `HEX3..0` = 3F, 79, 24, 00. `S` = F6 → `HEX3..0` = 3F, 7F, 79, 40.
- `S` = 05 captured, `S` changed to 63 during SHIFT → that `Valid` shows 005. The next conversion shows 099. With `LZB` = 0 and `S` = 05 → `HEX2` = 40, `HEX1` = 40.
- `OF` = 1 on a capture edge only → `OFLed` = 1 and stays 1. `ClrOF` pulse → 0 next edge. `ClrOF` and captured `OF` = 1 on the same edge → `OFLed` = 1.
- `Reset` asserted on the 4th SHIFT cycle after outputs showed 127 → outputs return to reset values next edge, no `Valid`. The next completed conversion is correct.
